// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: dcache lookup, pipelined multi-beat memory reads,
// beat-wise stores with I/O back-pressure, and dcache update/invalidate on completion.
module mem_lsu #(
  parameter int          MEM_BYTES = 1,
  parameter int          RD_LAT    = 1,
  parameter logic [31:0] IO_BASE   = 32'h30000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_i,
  input  logic                   we_i,
  input  logic [1:0]             size_i,
  input  logic                   uns_i,
  input  logic [31:0]            addr_i,
  input  logic [31:0]            wdata_i,
  input  logic [4:0]             rd_i,
  output logic                   stall_o,
  output logic                   done_o,
  output logic [31:0]            rdata_o,
  output logic [4:0]             rd_o,
  output logic                   mem_wr_o,
  output logic [31:0]            mem_a_o,
  output logic [MEM_BYTES-1:0]   mem_be_o,
  output logic [8*MEM_BYTES-1:0] mem_dout_o,
  input  logic [8*MEM_BYTES-1:0] mem_din_i,
  input  logic                   io_full_i,
  output logic                   dcache_re_o,
  output logic [31:0]            dcache_raddr_o,
  input  logic                   dcache_hit_i,
  input  logic [31:0]            dcache_data_i,
  output logic                   dcache_we_o,
  output logic                   dcache_inv_o,
  output logic [31:0]            dcache_waddr_o,
  output logic [31:0]            dcache_wdata_o,
  output logic [1:0]             dbg_state
);

  // Handshake: req_i rises with a request and stays high until done_o; done_o
  // pulses for exactly one cycle and the requester drops or replaces req_i then.

  typedef enum logic [1:0] {IDLE, LOOKUP, XFER, DONE} state_t;
  state_t state_q, state_d;

  logic [31:0]       addr_q, wdata_q, asm_q, asm_d, rdata_q;
  logic              we_q, uns_q, io_q, hit_q;
  logic [1:0]        size_q;
  logic [4:0]        rd_q, rd_out_q;
  logic [2:0]        nbeats_q, iss_cnt_q, cap_cnt_q;
  logic [RD_LAT-1:0] pipe_q;

  logic              req_io, accept, issue, store_beat, store_go;
  logic              capture, last_cap, last_store;
  logic [3:0]        bytes_w, rem_bytes;
  logic [31:0]       beat_addr, store_word;

  function automatic logic [3:0] size_bytes(input logic [1:0] s);
    case (s)
      2'b00:   return 4'd1;
      2'b01:   return 4'd2;
      default: return 4'd4;
    endcase
  endfunction

  function automatic logic [2:0] beats_for(input logic [1:0] s);
    return 3'((int'(size_bytes(s)) + MEM_BYTES - 1) / MEM_BYTES);
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] s,
                                         input logic u);
    case (s)
      2'b00:   return {{24{w[7] & ~u}}, w[7:0]};
      2'b01:   return {{16{w[15] & ~u}}, w[15:0]};
      default: return w;
    endcase
  endfunction

  assign req_io     = (addr_i >= IO_BASE);
  assign accept     = (state_q == IDLE) && req_i;
  assign bytes_w    = size_bytes(size_q);
  assign issue      = (state_q == XFER) && !we_q && (iss_cnt_q < nbeats_q);
  assign store_beat = (state_q == XFER) && we_q;
  assign store_go   = store_beat && !(io_q && io_full_i);
  // Capture runs RD_LAT cycles behind issue, tracked by a shift of issue strobes.
  assign capture    = (state_q == XFER) && !we_q && pipe_q[RD_LAT-1];
  assign last_cap   = capture && (cap_cnt_q == nbeats_q - 3'd1);
  assign last_store = store_go && (iss_cnt_q == nbeats_q - 3'd1);
  assign beat_addr  = addr_q + 32'(iss_cnt_q) * 32'(MEM_BYTES);
  assign rem_bytes  = bytes_w - 4'(int'(iss_cnt_q) * MEM_BYTES);
  assign store_word = wdata_q >> (6'(iss_cnt_q) * 6'(8 * MEM_BYTES));

  always_comb begin
    asm_d = asm_q;
    if (capture) begin
      for (int i = 0; i < MEM_BYTES; i++) begin
        if (int'(cap_cnt_q) * MEM_BYTES + i < 4)
          asm_d[(int'(cap_cnt_q) * MEM_BYTES + i) * 8 +: 8] = mem_din_i[i * 8 +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_i) state_d = (!we_i && !req_io) ? LOOKUP : XFER;
      LOOKUP:  state_d = dcache_hit_i ? DONE : XFER;
      XFER:    if (last_cap || last_store) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_wr_o   = 1'b0;
    mem_a_o    = '0;
    mem_be_o   = '0;
    mem_dout_o = '0;
    if (issue || store_beat) begin
      mem_a_o = beat_addr;
      for (int i = 0; i < MEM_BYTES; i++) mem_be_o[i] = (4'(i) < rem_bytes);
    end
    if (store_go) begin
      mem_wr_o   = 1'b1;
      mem_dout_o = store_word[8*MEM_BYTES-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      rd_q      <= '0;
      io_q      <= 1'b0;
      hit_q     <= 1'b0;
      nbeats_q  <= '0;
      iss_cnt_q <= '0;
      cap_cnt_q <= '0;
      pipe_q    <= '0;
      asm_q     <= '0;
      rdata_q   <= '0;
      rd_out_q  <= '0;
    end else begin
      state_q <= state_d;
      pipe_q  <= (pipe_q << 1) | RD_LAT'(issue);
      asm_q   <= asm_d;
      if (issue || store_go) iss_cnt_q <= iss_cnt_q + 3'd1;
      if (capture) cap_cnt_q <= cap_cnt_q + 3'd1;
      if (accept) begin
        addr_q    <= addr_i;
        wdata_q   <= wdata_i;
        we_q      <= we_i;
        size_q    <= size_i;
        uns_q     <= uns_i;
        rd_q      <= rd_i;
        io_q      <= req_io;
        nbeats_q  <= beats_for(size_i);
        hit_q     <= 1'b0;
        iss_cnt_q <= '0;
        cap_cnt_q <= '0;
        pipe_q    <= '0;
        asm_q     <= '0;
      end
      if (state_q == LOOKUP && dcache_hit_i) begin
        hit_q    <= 1'b1;
        rdata_q  <= extend(dcache_data_i >> {addr_q[1:0], 3'b000}, size_q, uns_q);
        rd_out_q <= rd_q;
      end
      if (last_cap) begin
        rdata_q  <= extend(asm_d, size_q, uns_q);
        rd_out_q <= rd_q;
      end
    end
  end

  assign done_o         = (state_q == DONE);
  assign stall_o        = req_i && !done_o;
  assign rdata_o        = rdata_q;
  assign rd_o           = rd_out_q;
  assign dbg_state      = state_q;
  assign dcache_re_o    = rst && accept && !we_i && !req_io;
  assign dcache_raddr_o = dcache_re_o ? addr_i : '0;
  // Word stores and word load fills keep the line; partial stores drop it.
  assign dcache_we_o    = done_o && !io_q && size_q[1] && (we_q || !hit_q);
  assign dcache_inv_o   = done_o && !io_q && we_q && !size_q[1];
  assign dcache_waddr_o = (dcache_we_o || dcache_inv_o) ? addr_q : '0;
  assign dcache_wdata_o = dcache_we_o ? (we_q ? wdata_q : asm_q) : '0;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: three widths/latencies share stimulus, a byte-array
// memory model answers reads, and load results go through an expected queue.
module tb_mem_lsu;

  logic        clk, rst;
  logic        req_s, we, uns, io_full, hit;
  logic [1:0]  size;
  logic [31:0] addr, wdata, hdata;
  logic [4:0]  rd;
  logic [2:0]  sel;

  logic        stall1, done1, wr1, re1, dwe1, dinv1;
  logic [31:0] rdata1, a1, raddr1, dwa1, dwd1;
  logic [4:0]  rdo1;
  logic [0:0]  be1;
  logic [7:0]  dout1, din1;
  logic [1:0]  st1;

  logic        stall2, done2, wr2, re2, dwe2, dinv2;
  logic [31:0] rdata2, a2, raddr2, dwa2, dwd2;
  logic [4:0]  rdo2;
  logic [1:0]  be2;
  logic [15:0] dout2, din2;
  logic [1:0]  st2;

  logic        stall4, done4, wr4, re4, dwe4, dinv4;
  logic [31:0] rdata4, a4, raddr4, dwa4, dwd4;
  logic [4:0]  rdo4;
  logic [3:0]  be4;
  logic [31:0] dout4, din4;
  logic [1:0]  st4;

  logic        stall_m, done_m, wr_m, re_m, dwe_m, dinv_m;
  logic [31:0] rdata_m, a_m, dwa_m, dwd_m, dout_m;
  logic [4:0]  rd_m;
  logic [3:0]  be_m;
  logic [1:0]  st_m;

  logic [7:0]  mem_m [logic [31:0]];
  logic [31:0] a2_d1, a4_d1, a4_d2;
  logic [31:0] exp_q [$];

  int errors = 0;
  int checks = 0;
  int lat, nbeat, first_beat, wr_full, dwe_n, dinv_n, aborted;
  logic [31:0] dwa_s, dwd_s, dout_s;
  logic [3:0]  be_s;
  logic        re0, stall0, stall_done;

  mem_lsu #(.MEM_BYTES(1), .RD_LAT(1)) u1 (
    .clk(clk), .rst(rst), .req_i(req_s && sel == 3'd1), .we_i(we), .size_i(size),
    .uns_i(uns), .addr_i(addr), .wdata_i(wdata), .rd_i(rd), .stall_o(stall1),
    .done_o(done1), .rdata_o(rdata1), .rd_o(rdo1), .mem_wr_o(wr1), .mem_a_o(a1),
    .mem_be_o(be1), .mem_dout_o(dout1), .mem_din_i(din1), .io_full_i(io_full),
    .dcache_re_o(re1), .dcache_raddr_o(raddr1), .dcache_hit_i(hit),
    .dcache_data_i(hdata), .dcache_we_o(dwe1), .dcache_inv_o(dinv1),
    .dcache_waddr_o(dwa1), .dcache_wdata_o(dwd1), .dbg_state(st1));

  mem_lsu #(.MEM_BYTES(2), .RD_LAT(2)) u2 (
    .clk(clk), .rst(rst), .req_i(req_s && sel == 3'd2), .we_i(we), .size_i(size),
    .uns_i(uns), .addr_i(addr), .wdata_i(wdata), .rd_i(rd), .stall_o(stall2),
    .done_o(done2), .rdata_o(rdata2), .rd_o(rdo2), .mem_wr_o(wr2), .mem_a_o(a2),
    .mem_be_o(be2), .mem_dout_o(dout2), .mem_din_i(din2), .io_full_i(io_full),
    .dcache_re_o(re2), .dcache_raddr_o(raddr2), .dcache_hit_i(hit),
    .dcache_data_i(hdata), .dcache_we_o(dwe2), .dcache_inv_o(dinv2),
    .dcache_waddr_o(dwa2), .dcache_wdata_o(dwd2), .dbg_state(st2));

  mem_lsu #(.MEM_BYTES(4), .RD_LAT(3)) u4 (
    .clk(clk), .rst(rst), .req_i(req_s && sel == 3'd4), .we_i(we), .size_i(size),
    .uns_i(uns), .addr_i(addr), .wdata_i(wdata), .rd_i(rd), .stall_o(stall4),
    .done_o(done4), .rdata_o(rdata4), .rd_o(rdo4), .mem_wr_o(wr4), .mem_a_o(a4),
    .mem_be_o(be4), .mem_dout_o(dout4), .mem_din_i(din4), .io_full_i(io_full),
    .dcache_re_o(re4), .dcache_raddr_o(raddr4), .dcache_hit_i(hit),
    .dcache_data_i(hdata), .dcache_we_o(dwe4), .dcache_inv_o(dinv4),
    .dcache_waddr_o(dwa4), .dcache_wdata_o(dwd4), .dbg_state(st4));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    return mem_m.exists(a) ? mem_m[a] : 8'h00;
  endfunction

  // memory model: data for the address seen RD_LAT cycles earlier
  always @(posedge clk) begin
    din1  <= rd_byte(a1);
    a2_d1 <= a2;
    din2  <= {rd_byte(a2_d1 + 32'd1), rd_byte(a2_d1)};
    a4_d1 <= a4;
    a4_d2 <= a4_d1;
    din4  <= {rd_byte(a4_d2 + 32'd3), rd_byte(a4_d2 + 32'd2),
              rd_byte(a4_d2 + 32'd1), rd_byte(a4_d2)};
  end

  always_comb begin
    stall_m = stall4; done_m = done4; wr_m = wr4; re_m = re4; dwe_m = dwe4;
    dinv_m = dinv4; rdata_m = rdata4; a_m = a4; dwa_m = dwa4; dwd_m = dwd4;
    dout_m = dout4; rd_m = rdo4; be_m = be4; st_m = st4;
    if (sel == 3'd1) begin
      stall_m = stall1; done_m = done1; wr_m = wr1; re_m = re1; dwe_m = dwe1;
      dinv_m = dinv1; rdata_m = rdata1; a_m = a1; dwa_m = dwa1; dwd_m = dwd1;
      dout_m = {24'b0, dout1}; rd_m = rdo1; be_m = {3'b0, be1}; st_m = st1;
    end else if (sel == 3'd2) begin
      stall_m = stall2; done_m = done2; wr_m = wr2; re_m = re2; dwe_m = dwe2;
      dinv_m = dinv2; rdata_m = rdata2; a_m = a2; dwa_m = dwa2; dwd_m = dwd2;
      dout_m = {16'b0, dout2}; rd_m = rdo2; be_m = {2'b0, be2}; st_m = st2;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver: one request on unit `unit`, monitored cycle by cycle until done_o
  task automatic run_op(input logic [2:0] unit, input logic op_we, input logic [1:0] op_size,
                        input logic op_uns, input logic [31:0] op_addr,
                        input logic [31:0] op_wdata, input logic op_hit,
                        input logic [31:0] op_hdata, input int full_n,
                        input logic [4:0] op_rd);
    int mb;
    logic beat;
    mb = (unit == 3'd1) ? 1 : (unit == 3'd2) ? 2 : 4;
    sel = unit; we = op_we; size = op_size; uns = op_uns; addr = op_addr;
    wdata = op_wdata; hit = op_hit; hdata = op_hdata; rd = op_rd; io_full = 1'b0;
    req_s = 1'b1;
    #1;
    re0 = re_m; stall0 = stall_m;
    lat = -1; nbeat = 0; first_beat = -1; wr_full = 0; dwe_n = 0; dinv_n = 0;
    dwa_s = '0; dwd_s = '0; dout_s = '0; be_s = '0; stall_done = 1'b1;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(negedge clk);
      io_full = (c <= full_n);
      #1;
      beat = op_we ? wr_m : (a_m != 32'd0);
      if (beat) begin
        if (first_beat < 0) begin
          first_beat = c; be_s = be_m; dout_s = dout_m;
        end
        check("beat_addr", a_m, op_addr + 32'(nbeat * mb));
        nbeat++;
      end
      if (io_full && wr_m) wr_full++;
      if (dwe_m) begin dwe_n++; dwa_s = dwa_m; dwd_s = dwd_m; end
      if (dinv_m) begin dinv_n++; dwa_s = dwa_m; end
      if (done_m) begin
        lat = c;
        stall_done = stall_m;
        req_s = 1'b0;
        if (!op_we) begin
          if (exp_q.size() > 0) check("rdata", rdata_m, exp_q.pop_front());
          check("rd_o", {27'b0, rd_m}, {27'b0, op_rd});
        end
      end
    end
    io_full = 1'b0;
    req_s = 1'b0;
    check("done_seen", 32'(lat >= 0), 32'd1);
    @(negedge clk);
    #1;
    check("done_single", {31'b0, done_m}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; req_s = 1'b0; sel = 3'd1; we = 1'b0; size = 2'b00; uns = 1'b0;
    addr = '0; wdata = '0; rd = '0; io_full = 1'b0; hit = 1'b0; hdata = '0;
    mem_m[32'h100] = 8'h11; mem_m[32'h101] = 8'h22;
    mem_m[32'h102] = 8'h33; mem_m[32'h103] = 8'h84;
    mem_m[32'h200] = 8'h80; mem_m[32'h202] = 8'h34; mem_m[32'h203] = 8'hF2;
    mem_m[32'h30010] = 8'h01; mem_m[32'h30011] = 8'h02;
    mem_m[32'h30012] = 8'h03; mem_m[32'h30013] = 8'h04;

    repeat (3) @(negedge clk);
    #1;
    check("rst_done", {31'b0, done1}, 32'd0);
    check("rst_rdata", rdata4, 32'd0);
    check("rst_mem_a", a2, 32'd0);
    check("rst_state", {30'b0, st1}, 32'd0);
    check("rst_dwe", {31'b0, dwe4}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;

    // word load miss, 1-byte beats
    exp_q.push_back(32'h84332211);
    run_op(3'd1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0, 0, 5'd3);
    check("lw_miss_lat", 32'(lat), 32'd7);
    check("lw_miss_first", 32'(first_beat), 32'd2);
    check("lw_miss_beats", 32'(nbeat), 32'd4);
    check("lw_miss_re", {31'b0, re0}, 32'd1);
    check("lw_miss_stall0", {31'b0, stall0}, 32'd1);
    check("lw_miss_stall_done", {31'b0, stall_done}, 32'd0);
    check("lw_fill_n", 32'(dwe_n), 32'd1);
    check("lw_fill_addr", dwa_s, 32'h100);
    check("lw_fill_data", dwd_s, 32'h84332211);
    check("lw_miss_inv", 32'(dinv_n), 32'd0);

    // same load hits
    exp_q.push_back(32'hDEADBEEF);
    run_op(3'd1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1, 32'hDEADBEEF, 0, 5'd4);
    check("lw_hit_lat", 32'(lat), 32'd2);
    check("lw_hit_beats", 32'(nbeat), 32'd0);
    check("lw_hit_fill", 32'(dwe_n), 32'd0);

    // LB / LBU / LH on the 4-byte, latency-3 unit
    exp_q.push_back(32'hFFFFFF80);
    run_op(3'd4, 1'b0, 2'b00, 1'b0, 32'h200, 32'h0, 1'b0, 32'h0, 0, 5'd5);
    check("lb_lat", 32'(lat), 32'd6);
    check("lb_fill", 32'(dwe_n), 32'd0);
    exp_q.push_back(32'h00000080);
    run_op(3'd4, 1'b0, 2'b00, 1'b1, 32'h200, 32'h0, 1'b0, 32'h0, 0, 5'd6);
    check("lbu_lat", 32'(lat), 32'd6);
    check("lbu_beats", 32'(nbeat), 32'd1);
    exp_q.push_back(32'hFFFFF234);
    run_op(3'd4, 1'b0, 2'b01, 1'b0, 32'h202, 32'h0, 1'b0, 32'h0, 0, 5'd7);
    check("lh_lat", 32'(lat), 32'd6);

    // uncached word load bypasses the dcache
    exp_q.push_back(32'h04030201);
    run_op(3'd1, 1'b0, 2'b10, 1'b0, 32'h30010, 32'h0, 1'b0, 32'h0, 0, 5'd8);
    check("io_lw_lat", 32'(lat), 32'd6);
    check("io_lw_first", 32'(first_beat), 32'd1);
    check("io_lw_re", {31'b0, re0}, 32'd0);
    check("io_lw_fill", 32'(dwe_n), 32'd0);

    // half store, 2-byte beats, invalidates
    run_op(3'd2, 1'b1, 2'b01, 1'b0, 32'h301, 32'h0000ABCD, 1'b0, 32'h0, 0, 5'd0);
    check("sh_lat", 32'(lat), 32'd2);
    check("sh_beats", 32'(nbeat), 32'd1);
    check("sh_be", {28'b0, be_s}, 32'h3);
    check("sh_dout", dout_s, 32'hABCD);
    check("sh_inv_n", 32'(dinv_n), 32'd1);
    check("sh_inv_addr", dwa_s, 32'h301);
    check("sh_we_n", 32'(dwe_n), 32'd0);

    // I/O word store held by io_full for 3 cycles
    run_op(3'd2, 1'b1, 2'b10, 1'b0, 32'h30004, 32'h12345678, 1'b0, 32'h0, 3, 5'd0);
    check("sw_io_lat", 32'(lat), 32'd6);
    check("sw_io_first", 32'(first_beat), 32'd4);
    check("sw_io_beats", 32'(nbeat), 32'd2);
    check("sw_io_wr_full", 32'(wr_full), 32'd0);
    check("sw_io_dout", dout_s, 32'h5678);
    check("sw_io_dc", 32'(dwe_n + dinv_n), 32'd0);

    // cached word store updates the line
    run_op(3'd4, 1'b1, 2'b10, 1'b0, 32'h400, 32'hCAFEF00D, 1'b0, 32'h0, 0, 5'd0);
    check("sw_lat", 32'(lat), 32'd2);
    check("sw_be", {28'b0, be_s}, 32'hF);
    check("sw_we_n", 32'(dwe_n), 32'd1);
    check("sw_we_data", dwd_s, 32'hCAFEF00D);

    // reset during third beat of a miss load
    sel = 3'd1; we = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h100; hit = 1'b0;
    rd = 5'd9; req_s = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("rst_beat3_addr", a_m, 32'h102);
    rst = 1'b0;
    req_s = 1'b0;
    @(negedge clk);
    #1;
    check("rst_mid_state", {30'b0, st_m}, 32'd0);
    check("rst_mid_outs", {26'b0, done_m, wr_m, dwe_m, dinv_m, re_m, |be_m}, 32'd0);
    check("rst_mid_a", a_m, 32'd0);
    check("rst_mid_rdata", rdata_m, 32'd0);
    rst = 1'b1;
    aborted = 0;
    repeat (8) begin
      @(negedge clk);
      #1;
      if (done_m || dwe_m) aborted++;
    end
    check("rst_no_done", 32'(aborted), 32'd0);
    exp_q.push_back(32'h84332211);
    run_op(3'd1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0, 0, 5'd10);
    check("post_rst_lat", 32'(lat), 32'd7);
    check("post_rst_fill", 32'(dwe_n), 32'd1);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Parametrised load/store unit for the MEM stage. It sits between the EX/MEM latch and the external byte-addressed memory port, and replaces the fixed 8-bit sequencer. Memory port width and read latency are configurable. Read beats are pipelined, and an uncached I/O window bypasses the dcache and honours I/O back-pressure. Cache coherence for sub-word stores is handled correctly: sub-word stores invalidate the line, word stores update it.

## Interface
- MEM_BYTES, 1: bytes per memory beat; legal values 1, 2, 4.
- RD_LAT, 1: cycles from address presented to mem_din_i valid; ≥1.
- IO_BASE, 32'h30000: addresses ≥ IO_BASE are uncached I/O.
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-low.
- req_i  in  1  access request, held until done_o.
- we_i  in  1  1 = store, 0 = load.
- size_i  in  2  00 byte, 01 half, 10 word.
- uns_i  in  1  zero-extend load (LBU/LHU).
- addr_i  in  32  byte address.
- wdata_i  in  32  store data, little-endian.
- rd_i  in  5  load destination register.
- stall_o  out  1  combinational: req_i & ~done_o.
- done_o  out  1  one-cycle completion pulse.
- rdata_o  out  32  extended load result; valid with done_o and held until next done_o.
- rd_o  out  5  destination register for rdata_o.
- mem_wr_o  out  1  store beat.
- mem_a_o  out  32  beat byte address.
- mem_be_o  out  MEM_BYTES  byte enables for store beats.
- mem_dout_o  out  8*MEM_BYTES  store data; lane 0 = byte at mem_a_o.
- mem_din_i  in  8*MEM_BYTES  read data; lane 0 = byte at mem_a_o.
- io_full_i  in  1  I/O write buffer full.
- dcache_re_o  out  1  lookup strobe.
- dcache_raddr_o  out  32  lookup address.
- dcache_hit_i  in  1  hit, valid in the cycle after dcache_re_o.
- dcache_data_i  in  32  hit word, same timing as dcache_hit_i.
- dcache_we_o  out  1  word write/fill pulse.
- dcache_inv_o  out  1  invalidate pulse.
- dcache_waddr_o  out  32  write/invalidate address.
- dcache_wdata_o  out  32  write/fill data.

## Operation
- States: IDLE, LOOKUP, XFER, DONE.
- IDLE: on req_i, latch all request inputs.
  - Cached load → pulse dcache_re_o with addr_i, go to LOOKUP.
  - Otherwise → go to XFER.
- LOOKUP:
  - Hit → extract and extend from dcache_data_i, go to DONE.
  - Miss → go to XFER.
- XFER:
  - Beat count N = ceil(bytes/MEM_BYTES), where bytes = 1/2/4.
  - Beat k uses address addr + k*MEM_BYTES.
  - mem_be_o enables lanes below the remaining byte count; all others are 0.
  - Loads: one address is issued per cycle, back-to-back. A separate capture counter samples mem_din_i RD_LAT cycles after each issue and assembles bytes in order.
  - Stores: mem_wr_o=1 with data lanes from wdata_i.
    - For I/O addresses, a beat is held (mem_wr_o=0, address and counters frozen) while io_full_i=1.
    - Cached stores are never stalled by io_full_i.
  - After the last capture (loads) or the last beat (stores), go to DONE.
- DONE: pulse done_o, drive rdata_o/rd_o, perform the dcache side action, go to IDLE.
  - Cached word store → dcache_we_o, data = wdata.
  - Cached sub-word store → dcache_inv_o.
  - Cached word load miss → dcache_we_o fill with the assembled word.
  - Sub-word miss and I/O access → no cache action.
- Sign extension: bit 7 (byte) or bit 15 (half) unless uns_i; words are unchanged.
- Outside XFER beats: mem_wr_o=0, mem_a_o=0, mem_be_o=0.
- Alignment is not checked; byte addresses are passed through as computed.

## Timing
- Reset (rst=0 at a clock edge): state IDLE.
  - All outputs 0 except stall_o, which remains combinational.
  - Counters cleared; rdata_o=0.
  - A reset mid-XFER aborts the access with no dcache write or invalidate and no done_o.
- Request sampled in IDLE at cycle 0.
- Cached hit load: LOOKUP in cycle 1, done_o in cycle 2.
- Cached miss load: issue cycles 2..N+1, done_o at N+2+RD_LAT.
- Uncached load: issue cycles 1..N, done_o at N+1+RD_LAT.
- Store: beats in cycles 1..N plus io_full_i stall cycles; done_o one cycle after the last beat.
- The DONE cycle never accepts a new request. A held req_i is re-accepted in the following IDLE cycle, so the requester must update or drop req_i on done_o.
- dcache_we_o and dcache_inv_o are single-cycle pulses coincident with done_o.

## Test plan
- MEM_BYTES=1, RD_LAT=1, LW 0x100 miss, memory bytes 0x11,0x22,0x33,0x84 → addresses 0x100..0x103 in cycles 2–5, done_o in cycle 7, rdata_o=0x84332211, dcache fill at 0x100.
- Repeat the same LW with dcache_hit_i=1, dcache_data_i=0xDEADBEEF → done_o in cycle 2, rdata_o=0xDEADBEEF, no mem_a_o activity.
- LB vs LBU at 0x200, byte 0x80 → LB gives 0xFFFFFF80, LBU gives 0x00000080; no fill; MEM_BYTES=4, RD_LAT=3 gives done_o in cycle 6.
- MEM_BYTES=2, SH 0x301 data 0xABCD → one beat, mem_be_o=2'b11, mem_dout_o=0xABCD, then dcache_inv_o at 0x301 with done_o.
- SW to 0x30004 with io_full_i=1 for 3 cycles → beats held, zero writes while full, done_o delayed by 3 cycles, no dcache action.
- rst=0 during the third beat of a miss LW → IDLE next cycle, all outputs 0, no fill, no done_o; a new request afterwards completes normally.
